// File: rtl/park_pkg.sv
`default_nettype none
// ============================================================================
// Module      : park_pkg
// Description : Shared state encoding and saturation helper for the Park
//               transform family.
// Revision    : 1.0 - initial release
// ============================================================================
package park_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4,
        S_SUM  = 3'd5
    } park_state_t;

    // Widest intermediate the helper accepts; covers D_WIDTH up to 64.
    localparam int c_SAT_MAX_W = 129;

    // Clamp a sign-extended wide value into the signed range of 'width' bits.
    function automatic logic signed [c_SAT_MAX_W-1:0] sat_clamp(
        input logic signed [c_SAT_MAX_W-1:0] value,
        input int                            width
    );
        logic signed [c_SAT_MAX_W-1:0] w_one;
        logic signed [c_SAT_MAX_W-1:0] w_hi;
        logic signed [c_SAT_MAX_W-1:0] w_lo;
        w_one = 1;
        w_hi  = (w_one <<< (width - 1)) - w_one;
        w_lo  = -w_hi - w_one;
        if (value > w_hi) begin
            return w_hi;
        end else if (value < w_lo) begin
            return w_lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/park_mul.sv
`default_nettype none
// ============================================================================
// Module      : park_mul
// Description : Combinational signed multiply followed by an arithmetic
//               right shift of Q_BITS (floor), full 2*D_WIDTH result kept.
// Revision    : 1.0 - initial release
// ============================================================================
module park_mul #(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10
) (
    input  logic signed [D_WIDTH-1:0]   i_a,
    input  logic signed [D_WIDTH-1:0]   i_b,
    output logic signed [2*D_WIDTH-1:0] o_p
);

    logic signed [2*D_WIDTH-1:0] w_full;

    // Operands are sign-extended first so the product is exact.
    assign w_full = (2*D_WIDTH)'(i_a) * (2*D_WIDTH)'(i_b);
    assign o_p    = w_full >>> Q_BITS;

endmodule
`default_nettype wire

// File: rtl/park_transform.sv
`default_nettype none
// ============================================================================
// Module      : park_transform
// Description : Multi-cycle Park transform (D/Q from alpha/beta, sin/cos)
//               sharing one multiplier. Define PARK_SAT_EN to saturate the
//               outputs instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
module park_transform
    import park_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic signed [D_WIDTH-1:0] sin,
    input  logic signed [D_WIDTH-1:0] cos,
    input  logic                      start,
    output logic signed [D_WIDTH-1:0] D,
    output logic signed [D_WIDTH-1:0] Q,
    output logic                      busy,
    output logic                      done
);

    park_state_t                 r_state;
    park_state_t                 w_next_state;
    logic signed [D_WIDTH-1:0]   r_alpha, r_beta, r_sin, r_cos;
    logic signed [D_WIDTH-1:0]   w_mul_a, w_mul_b;
    logic signed [2*D_WIDTH-1:0] w_prod;
    logic signed [2*D_WIDTH-1:0] r_p_ac, r_p_bs, r_p_as, r_p_bc;
    logic signed [2*D_WIDTH:0]   w_sum_d, w_sum_q;
    logic signed [D_WIDTH-1:0]   w_red_d, w_red_q;
    logic signed [D_WIDTH-1:0]   r_d, r_q;
    logic                        r_done;
    logic                        w_load;
    logic                        w_busy;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_M0;
            S_M0:    w_next_state = S_M1;
            S_M1:    w_next_state = S_M2;
            S_M2:    w_next_state = S_M3;
            S_M3:    w_next_state = S_SUM;
            S_SUM:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand steering for the shared multiplier, one product per state.
    always_comb begin
        w_busy  = (r_state != S_IDLE);
        w_load  = (r_state == S_IDLE) && start;
        w_mul_a = r_alpha;
        w_mul_b = r_cos;
        case (r_state)
            S_M1: begin w_mul_a = r_beta;  w_mul_b = r_sin; end
            S_M2: begin w_mul_a = r_alpha; w_mul_b = r_sin; end
            S_M3: begin w_mul_a = r_beta;  w_mul_b = r_cos; end
            default: ;
        endcase
    end

    park_mul #(
        .D_WIDTH (D_WIDTH),
        .Q_BITS  (Q_BITS)
    ) u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    assign w_sum_d = (2*D_WIDTH+1)'(r_p_ac) + (2*D_WIDTH+1)'(r_p_bs);
    assign w_sum_q = (2*D_WIDTH+1)'(r_p_bc) - (2*D_WIDTH+1)'(r_p_as);

`ifdef PARK_SAT_EN
    logic signed [c_SAT_MAX_W-1:0] w_sat_d, w_sat_q;
    logic                          w_unused_sat;
    assign w_sat_d      = sat_clamp(c_SAT_MAX_W'(w_sum_d), D_WIDTH);
    assign w_sat_q      = sat_clamp(c_SAT_MAX_W'(w_sum_q), D_WIDTH);
    assign w_red_d      = w_sat_d[D_WIDTH-1:0];
    assign w_red_q      = w_sat_q[D_WIDTH-1:0];
    assign w_unused_sat = ^{w_sat_d[c_SAT_MAX_W-1:D_WIDTH], w_sat_q[c_SAT_MAX_W-1:D_WIDTH]};
`else
    // Two's-complement wrap: upper sum bits are deliberately discarded.
    logic w_unused_wrap;
    assign w_red_d       = w_sum_d[D_WIDTH-1:0];
    assign w_red_q       = w_sum_q[D_WIDTH-1:0];
    assign w_unused_wrap = ^{w_sum_d[2*D_WIDTH:D_WIDTH], w_sum_q[2*D_WIDTH:D_WIDTH]};
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_alpha <= '0;
            r_beta  <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_p_ac  <= '0;
            r_p_bs  <= '0;
            r_p_as  <= '0;
            r_p_bc  <= '0;
            r_d     <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_load) begin
                r_alpha <= alpha;
                r_beta  <= beta;
                r_sin   <= sin;
                r_cos   <= cos;
            end
            case (r_state)
                S_M0:    r_p_ac <= w_prod;
                S_M1:    r_p_bs <= w_prod;
                S_M2:    r_p_as <= w_prod;
                S_M3:    r_p_bc <= w_prod;
                S_SUM: begin
                    r_d <= w_red_d;
                    r_q <= w_red_q;
                end
                default: ;
            endcase
            r_done <= (r_state == S_SUM);
        end
    end

    assign D    = r_d;
    assign Q    = r_q;
    assign busy = w_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_park_transform.sv
`default_nettype none
// ============================================================================
// Module      : tb_park_transform
// Description : Self-checking bench for park_transform (D_WIDTH=16, Q_BITS=10)
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_park_transform;

    localparam int DW = 16;
    localparam int QB = 10;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic signed [DW-1:0] alpha, beta, sin, cos;
    logic                 start;
    logic signed [DW-1:0] D, Q;
    logic                 busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    park_transform #(.D_WIDTH(DW), .Q_BITS(QB)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .alpha (alpha),
        .beta  (beta),
        .sin   (sin),
        .cos   (cos),
        .start (start),
        .D     (D),
        .Q     (Q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference model: exact products, floor division by 2^QB, then reduction.
    function automatic longint floor_q(input longint x);
        longint r;
        r = x / (longint'(1) << QB);
        if ((x % (longint'(1) << QB)) != 0 && x < 0) r = r - 1;
        return r;
    endfunction

    function automatic logic signed [DW-1:0] reduce(input longint v);
`ifdef PARK_SAT_EN
        longint hi, lo;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return DW'(hi);
        if (v < lo) return DW'(lo);
        return DW'(v);
`else
        return DW'(v);
`endif
    endfunction

    task automatic model(input int a, input int b, input int s, input int c,
                         output logic signed [DW-1:0] ed, output logic signed [DW-1:0] eq);
        ed = reduce(floor_q(longint'(a) * c) + floor_q(longint'(b) * s));
        eq = reduce(floor_q(longint'(b) * c) - floor_q(longint'(a) * s));
    endtask

    function automatic int rnd16();
        logic signed [DW-1:0] v;
        v = DW'($urandom);
        return int'(v);
    endfunction

    task automatic launch(input int a, input int b, input int s, input int c);
        alpha = DW'(a); beta = DW'(b); sin = DW'(s); cos = DW'(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts sampled cycles until done, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; start = 1'b0;
        alpha = '0; beta = '0; sin = '0; cos = '0;
        #3;
        n_tests += 4;
        if (D !== 16'sd0)   begin n_fail++; $display("FAIL reset_D: got %0d expected 0", D); end
        if (Q !== 16'sd0)   begin n_fail++; $display("FAIL reset_Q: got %0d expected 0", Q); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    task automatic test_directed();
        int va[4], vb[4], vs[4], vc[4], xd[4], xq[4];
        int n, busy_cnt;
        va = '{100, 100, -3, 32767};
        vb = '{-50, -50, 0, 32767};
        vs = '{0, 1024, 0, 1024};
        vc = '{1024, 0, 512, 1024};
`ifdef PARK_SAT_EN
        xd = '{100, -50, -2, 32767};
`else
        xd = '{100, -50, -2, -2};
`endif
        xq = '{-50, -100, 0, 0};
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], vs[i], vc[i]);
            busy_cnt = (busy === 1'b1) ? 1 : 0;
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
                if (busy === 1'b1) busy_cnt++;
            end
            n_tests += 4;
            if (n != 5)          begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 5", i, n); end
            if (D !== DW'(xd[i])) begin n_fail++; $display("FAIL dir%0d_D: got %0d expected %0d", i, D, xd[i]); end
            if (Q !== DW'(xq[i])) begin n_fail++; $display("FAIL dir%0d_Q: got %0d expected %0d", i, Q, xq[i]); end
            if (busy_cnt != 5)   begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected 5", i, busy_cnt); end
            @(posedge clk); #1;
            n_tests++;
            if (done !== 1'b0)   begin n_fail++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_random();
        int a, b, s, c, n;
        logic signed [DW-1:0] ed, eq;
        for (int i = 0; i < 24; i++) begin
            a = rnd16(); b = rnd16();
            if (i % 3 == 0) begin
                s = rnd16(); c = rnd16();
            end else begin
                s = int'($urandom_range(0, 2048)) - 1024;
                c = int'($urandom_range(0, 2048)) - 1024;
            end
            model(a, b, s, c, ed, eq);
            launch(a, b, s, c);
            wait_done(n);
            n_tests += 3;
            if (n != 5)  begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected 5", i, n); end
            if (D !== ed) begin n_fail++; $display("FAIL rnd%0d_D: got %0d expected %0d (a=%0d b=%0d s=%0d c=%0d)", i, D, ed, a, b, s, c); end
            if (Q !== eq) begin n_fail++; $display("FAIL rnd%0d_Q: got %0d expected %0d (a=%0d b=%0d s=%0d c=%0d)", i, Q, eq, a, b, s, c); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_busy();
        int a, b, s, c;
        logic signed [DW-1:0] ed, eq;
        a = rnd16(); b = rnd16();
        s = int'($urandom_range(0, 2048)) - 1024;
        c = int'($urandom_range(0, 2048)) - 1024;
        model(a, b, s, c, ed, eq);
        launch(a, b, s, c);
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alpha = DW'(rnd16()); beta = DW'(rnd16()); sin = DW'(rnd16()); cos = DW'(rnd16());
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_tests += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b expected 1", done); end
        if (D !== ed)      begin n_fail++; $display("FAIL ign_D: got %0d expected %0d", D, ed); end
        if (Q !== eq)      begin n_fail++; $display("FAIL ign_Q: got %0d expected %0d", Q, eq); end
        @(posedge clk); #1;
        n_tests += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue_done: got %b expected 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue_busy: got %b expected 0", busy); end
        alpha = DW'(rnd16()); beta = DW'(rnd16());
        repeat (3) @(posedge clk);
        #1;
        n_tests += 2;
        if (D !== ed) begin n_fail++; $display("FAIL hold_D: got %0d expected %0d", D, ed); end
        if (Q !== eq) begin n_fail++; $display("FAIL hold_Q: got %0d expected %0d", Q, eq); end
    endtask

    task automatic test_back_to_back();
        int a0, b0, s0, c0, a1, b1, s1, c1, n, m;
        logic signed [DW-1:0] ed0, eq0, ed1, eq1;
        a0 = rnd16(); b0 = rnd16(); s0 = rnd16(); c0 = rnd16();
        a1 = rnd16(); b1 = rnd16(); s1 = rnd16(); c1 = rnd16();
        model(a0, b0, s0, c0, ed0, eq0);
        model(a1, b1, s1, c1, ed1, eq1);
        alpha = DW'(a0); beta = DW'(b0); sin = DW'(s0); cos = DW'(c0);
        start = 1'b1;
        @(posedge clk); #1;
        alpha = DW'(a1); beta = DW'(b1); sin = DW'(s1); cos = DW'(c1);
        wait_done(n);
        n_tests += 3;
        if (n != 5)    begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 5", n); end
        if (D !== ed0) begin n_fail++; $display("FAIL b2b_first_D: got %0d expected %0d", D, ed0); end
        if (Q !== eq0) begin n_fail++; $display("FAIL b2b_first_Q: got %0d expected %0d", Q, eq0); end
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
            if (m == 1) start = 1'b0;
        end while (done !== 1'b1 && m < 20);
        n_tests += 3;
        if (m != 6)    begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 6", m); end
        if (D !== ed1) begin n_fail++; $display("FAIL b2b_second_D: got %0d expected %0d", D, ed1); end
        if (Q !== eq1) begin n_fail++; $display("FAIL b2b_second_Q: got %0d expected %0d", Q, eq1); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int a, b, s, c, n, seen;
        logic signed [DW-1:0] ed, eq;
        launch(100, -50, 0, 1024);
        wait_done(n);
        n_tests += 2;
        if (D !== 16'sd100) begin n_fail++; $display("FAIL abort_pre_D: got %0d expected 100", D); end
        if (Q !== -16'sd50) begin n_fail++; $display("FAIL abort_pre_Q: got %0d expected -50", Q); end
        @(posedge clk); #1;
        launch(rnd16(), rnd16(), rnd16(), rnd16());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstb = 1'b0;
        #1;
        n_tests += 4;
        if (D !== 16'sd0)  begin n_fail++; $display("FAIL abort_D: got %0d expected 0", D); end
        if (Q !== 16'sd0)  begin n_fail++; $display("FAIL abort_Q: got %0d expected 0", Q); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
        a = rnd16(); b = rnd16();
        s = int'($urandom_range(0, 2048)) - 1024;
        c = int'($urandom_range(0, 2048)) - 1024;
        model(a, b, s, c, ed, eq);
        launch(a, b, s, c);
        wait_done(n);
        n_tests += 3;
        if (n != 5)   begin n_fail++; $display("FAIL post_abort_latency: got %0d expected 5", n); end
        if (D !== ed) begin n_fail++; $display("FAIL post_abort_D: got %0d expected %0d", D, ed); end
        if (Q !== eq) begin n_fail++; $display("FAIL post_abort_Q: got %0d expected %0d", Q, eq); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
